// File: rtl/fc_seq.sv
// fc_seq: sequencer + 3-neuron multiply-accumulate controller for the fully-connected layer.
// Latency: last input accepted in cycle t -> out_valid high in cycle t+2.
// Backpressure: in_ready drops for the whole drain/present phase; results hold while out_ready=0.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   clr                synchronous abort of the vector in progress (discards any result)
//   in_valid/in_ready  input value handshake, in_data = signed normalized input
//   w_addr, w0..w2     synchronous weight ROM: address out, 3 weights back one cycle later
//   out_valid/ready    result handshake, out0..out2 = signed neuron sums
//   busy               a vector is partially consumed, draining, or being presented
module fc_seq #(
    parameter int IN_W   = 22,
    parameter int W_W    = 8,
    parameter int ACC_W  = 40,
    parameter int N_IN   = 16,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_W-1:0]   in_data,
    output logic        [ADDR_W-1:0] w_addr,
    input  logic signed [W_W-1:0]    w0,
    input  logic signed [W_W-1:0]    w1,
    input  logic signed [W_W-1:0]    w2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out0,
    output logic signed [ACC_W-1:0]  out1,
    output logic signed [ACC_W-1:0]  out2,
    output logic                     busy
);

    localparam int P_W = IN_W + W_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_IN - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    // The three ROM weights travel together as one word.
    typedef struct packed {
        logic signed [W_W-1:0] w2;
        logic signed [W_W-1:0] w1;
        logic signed [W_W-1:0] w0;
    } wvec_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_W-1:0]       idx;
    logic signed [IN_W-1:0]  p_data;
    logic                    p_vld;
    logic signed [ACC_W-1:0] acc0;
    logic signed [ACC_W-1:0] acc1;
    logic signed [ACC_W-1:0] acc2;
    logic                    accept;
    logic                    idx_last;
    logic                    out_fire;
    wvec_t                   wv;
    logic signed [P_W-1:0]   prod0;
    logic signed [P_W-1:0]   prod1;
    logic signed [P_W-1:0]   prod2;

    assign wv = '{w2: w2, w1: w1, w0: w0};

    // Full-width signed products; the weights on the bus now belong to the
    // element captured in p_data last cycle (ROM is one cycle behind w_addr).
    assign prod0 = P_W'(p_data) * P_W'(wv.w0);
    assign prod1 = P_W'(p_data) * P_W'(wv.w1);
    assign prod2 = P_W'(p_data) * P_W'(wv.w2);

    assign in_ready = (state == S_RUN);
    assign accept   = in_valid && in_ready;
    assign idx_last = (idx == LAST_IDX);
    assign out_fire = out_valid && out_ready;

    // idx already points at the next element, so the ROM read for it is
    // issued as soon as the previous one is accepted.
    assign w_addr = idx;
    assign out0   = acc0;
    assign out1   = acc1;
    assign out2   = acc2;
    assign busy   = (idx != '0) || (state == S_DRAIN) || (state == S_OUT);

    // ------------------------------------------------------------------
    // FSM next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (accept && idx_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Final product is folded into the sums during this cycle.
                state_nxt = S_OUT;
            end
            S_OUT: begin
                if (out_fire) begin
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
        if (clr) begin
            state_nxt = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Input capture / index counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx    <= '0;
            p_vld  <= 1'b0;
            p_data <= '0;
        end else begin
            p_vld <= accept;
            if (accept) begin
                p_data <= in_data;
                if (idx_last) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulators and result handshake
    // ------------------------------------------------------------------
    // p_vld is never set while a result is presented, so clearing on
    // handshake cannot collide with a pending MAC.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc0      <= '0;
            acc1      <= '0;
            acc2      <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_fire) begin
                acc0 <= '0;
                acc1 <= '0;
                acc2 <= '0;
            end else if (p_vld) begin
                // Sign-extend each product; sums wrap modulo 2^ACC_W.
                acc0 <= acc0 + ACC_W'(prod0);
                acc1 <= acc1 + ACC_W'(prod1);
                acc2 <= acc2 + ACC_W'(prod2);
            end

            if (state == S_DRAIN) begin
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fc_seq.sv
// tb_fc_seq: directed + randomized bench for fc_seq with N_IN=4 and a behavioural ROM.
// Latency: expects out_valid two cycles after the last accepted input.
// Backpressure: exercises in_valid gaps and out_ready held low while a result is presented.
module tb_fc_seq;

    localparam int IN_W   = 22;
    localparam int W_W    = 8;
    localparam int ACC_W  = 40;
    localparam int N_IN   = 4;
    localparam int ADDR_W = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     clr;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [IN_W-1:0]   in_data;
    logic        [ADDR_W-1:0] w_addr;
    logic signed [W_W-1:0]    w0;
    logic signed [W_W-1:0]    w1;
    logic signed [W_W-1:0]    w2;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out0;
    logic signed [ACC_W-1:0]  out1;
    logic signed [ACC_W-1:0]  out2;
    logic                     busy;

    int n_vec  = 0;
    int n_fail = 0;

    int rom [3][N_IN];       // weight k for element i
    int vec [N_IN];          // input values of the next vector
    int q_data [$];          // values the DUT actually accepted, in order
    int q_addr [$];          // w_addr seen at each accept
    logic signed [ACC_W-1:0] last0, last1, last2;

    fc_seq #(
        .IN_W  (IN_W),
        .W_W   (W_W),
        .ACC_W (ACC_W),
        .N_IN  (N_IN),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .w_addr   (w_addr),
        .w0       (w0),
        .w1       (w1),
        .w2       (w2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Synchronous weight ROM: data one cycle after address.
    always @(posedge clk) begin
        w0 <= W_W'(rom[0][w_addr]);
        w1 <= W_W'(rom[1][w_addr]);
        w2 <= W_W'(rom[2][w_addr]);
    end

    // Record what was accepted; rst/clr discard the partial vector.
    always @(posedge clk) begin
        if (rst || clr) begin
            q_data.delete();
            q_addr.delete();
        end else if (in_valid && in_ready) begin
            q_data.push_back(int'(in_data));
            q_addr.push_back(int'(w_addr));
        end
    end

    // Dot product of accepted inputs with the ROM column, wrapped to ACC_W bits.
    function automatic logic signed [ACC_W-1:0] model_sum(input int k);
        logic signed [ACC_W-1:0] s;
        longint p;
        s = '0;
        foreach (q_data[i]) begin
            p = longint'(q_data[i]) * longint'(rom[k][i]);
            s = s + ACC_W'(p);
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present vec[] with 'gap' idle cycles between values.
    task automatic feed(input int gap, input bit keep_valid);
        for (int i = 0; i < N_IN; i++) begin
            in_valid = 1'b1;
            in_data  = IN_W'(vec[i]);
            check("in_ready_run", in_ready, 1);
            step();
            if (i < N_IN - 1) begin
                in_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    check("gap_w_addr", w_addr, i + 1);
                    check("gap_busy", busy, 1);
                    step();
                end
            end
        end
        in_valid = keep_valid;
        in_data  = IN_W'($urandom);
    endtask

    // Now one cycle after the last accept (drain); result due next cycle.
    task automatic wait_out();
        int n;
        check("drain_out_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 0);
        step();
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("out_latency", n, 0);
    endtask

    task automatic collect(input int hold);
        logic signed [ACC_W-1:0] e0, e1, e2;
        e0 = model_sum(0);
        e1 = model_sum(1);
        e2 = model_sum(2);
        check("n_accepted", q_data.size(), N_IN);
        foreach (q_addr[i]) check("w_addr_seq", q_addr[i], i);
        check("out0", out0, e0);
        check("out1", out1, e1);
        check("out2", out2, e2);
        check("out_in_ready", in_ready, 0);
        check("out_busy", busy, 1);
        last0 = out0;
        last1 = out1;
        last2 = out2;
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_out0", out0, e0);
            check("hold_out2", out2, e2);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
        check("post_acc_clear", out1, 0);
        q_data.delete();
        q_addr.delete();
    endtask

    task automatic run_vec(input int gap, input int hold, input bit keep_valid);
        feed(gap, keep_valid);
        wait_out();
        collect(hold);
    endtask

    task automatic set_rom(input int a, input int b, input int c);
        for (int i = 0; i < N_IN; i++) begin
            rom[0][i] = a;
            rom[1][i] = b;
            rom[2][i] = c;
        end
    endtask

    initial begin
        logic signed [IN_W-1:0] r;
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        set_rom(0, 0, 0);
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_out0", out0, 0);

        // Basic vector 1..4 with constant weights
        set_rom(1, -1, 2);
        for (int i = 0; i < N_IN; i++) vec[i] = i + 1;
        run_vec(0, 0, 1'b0);
        check("t1_out0", last0, 10);
        check("t1_out1", last1, -10);
        check("t1_out2", last2, 20);

        // Most negative input, extreme weights: sign extension
        set_rom(-128, 127, -128);
        for (int i = 0; i < N_IN; i++) vec[i] = -(1 << 21);
        run_vec(0, 0, 1'b0);
        check("t2_out0", last0, 1073741824);
        check("t2_out1", last1, -1065353216);
        check("t2_out2", last2, 1073741824);

        // Gaps of 3 idle cycles, per-address weights
        for (int i = 0; i < N_IN; i++) begin
            vec[i]    = i + 1;
            rom[0][i] = i + 1;
            rom[1][i] = 3 - 2 * i;
            rom[2][i] = -i;
        end
        run_vec(3, 0, 1'b0);
        check("t3_out0", last0, 30);

        // Result held 5 cycles with in_valid high; next vector starts from zero
        set_rom(1, -1, 2);
        run_vec(0, 5, 1'b1);
        run_vec(0, 0, 1'b0);
        check("t4_next_out0", last0, 10);

        // clr after two of four inputs
        in_valid = 1'b1;
        in_data  = 22'sd100;
        step();
        in_data  = 22'sd200;
        step();
        in_valid = 1'b0;
        clr      = 1'b1;
        step();
        clr = 1'b0;
        check("clr_in_ready", in_ready, 1);
        check("clr_w_addr", w_addr, 0);
        check("clr_busy", busy, 0);
        check("clr_out_valid", out_valid, 0);
        for (int i = 0; i < N_IN; i++) vec[i] = i + 1;
        run_vec(0, 0, 1'b0);
        check("t5_out0", last0, 10);

        // rst while a result is presented
        feed(1, 1'b0);
        wait_out();
        check("t6_pre_out_valid", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_out_valid", out_valid, 0);
        check("t6_out0", out0, 0);
        check("t6_out1", out1, 0);
        check("t6_out2", out2, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_w_addr", w_addr, 0);
        check("t6_busy", busy, 0);
        q_data.delete();
        q_addr.delete();

        // Randomized vectors against the reference model
        for (int v = 0; v < 25; v++) begin
            for (int i = 0; i < N_IN; i++) begin
                r      = IN_W'($urandom);
                vec[i] = int'(r);
                for (int k = 0; k < 3; k++) rom[k][i] = int'($urandom_range(0, 255)) - 128;
            end
            run_vec(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
